// File: rtl/fetch_unit_pkg.sv
// Shared constants and FSM encoding for the IF-stage fetch controller.
package fetch_unit_pkg;

    localparam int                         FETCH_WORD_SIZE = 16;
    localparam logic [FETCH_WORD_SIZE-1:0] FETCH_RESET_PC  = 16'h0000;

    typedef enum logic [1:0] {
        FETCH_S_REQ   = 2'd0,
        FETCH_S_HAVE  = 2'd1,
        FETCH_S_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// IF stage: PC, imem read handshake, IF/ID register; one instruction per 2 cycles at best,
// stalls on pc_write/ir_write, drains uncancellable reads after flush. FETCH_NUM_INST_EN adds num_inst counter.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                   WORD_SIZE = FETCH_WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = FETCH_RESET_PC
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pc_write,
    input  logic                 ir_write,
    input  logic                 flush,
    input  logic [WORD_SIZE-1:0] flush_target,
    input  logic                 incr_num_inst,
    output logic                 i_read_req,
    output logic [WORD_SIZE-1:0] i_address,
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic                 i_ready,
    output logic [WORD_SIZE-1:0] ifid_inst,
    output logic [WORD_SIZE-1:0] ifid_pc_plus1,
    output logic                 ifid_valid,
    output logic [WORD_SIZE-1:0] num_inst
);

    fetch_state_e         state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] req_addr_q, req_addr_d;
    logic [WORD_SIZE-1:0] fb_q, fb_d;
    logic                 fb_valid_q, fb_valid_d;
    logic [WORD_SIZE-1:0] ifid_inst_q, ifid_inst_d;
    logic [WORD_SIZE-1:0] ifid_pc_plus1_q, ifid_pc_plus1_d;
    logic                 ifid_valid_q, ifid_valid_d;

    logic                 adv;
    logic                 consume;
    logic [WORD_SIZE-1:0] pc_plus1;

    assign adv      = pc_write & ir_write & ~flush;
    assign consume  = (state_q == FETCH_S_HAVE) & fb_valid_q & adv;
    assign pc_plus1 = pc_q + WORD_SIZE'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH_S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_S_REQ: begin
                if (flush) begin
                    state_d = i_ready ? FETCH_S_REQ : FETCH_S_DRAIN;
                end else if (i_ready) begin
                    state_d = FETCH_S_HAVE;
                end
            end
            FETCH_S_HAVE: begin
                if (flush || consume) begin
                    state_d = FETCH_S_REQ;
                end
            end
            FETCH_S_DRAIN: begin
                if (i_ready) begin
                    state_d = FETCH_S_REQ;
                end
            end
            default: state_d = FETCH_S_REQ;
        endcase
    end

    // Reset is folded in so no request is visible while reset_n is low.
    always_comb begin
        i_read_req = reset_n & ((state_q == FETCH_S_REQ) | (state_q == FETCH_S_DRAIN));
        i_address  = req_addr_q;
    end

    always_comb begin
        pc_d            = pc_q;
        req_addr_d      = req_addr_q;
        fb_d            = fb_q;
        fb_valid_d      = fb_valid_q;
        ifid_inst_d     = ifid_inst_q;
        ifid_pc_plus1_d = ifid_pc_plus1_q;
        ifid_valid_d    = ifid_valid_q;

        if (flush) begin
            pc_d       = flush_target;
            fb_valid_d = 1'b0;
            // An outstanding read without i_ready keeps its address until drained.
            if (i_ready || state_q == FETCH_S_HAVE) begin
                req_addr_d = flush_target;
            end
        end else begin
            case (state_q)
                FETCH_S_REQ: begin
                    if (i_ready) begin
                        fb_d       = i_data;
                        fb_valid_d = 1'b1;
                    end
                end
                FETCH_S_HAVE: begin
                    if (consume) begin
                        pc_d       = pc_plus1;
                        req_addr_d = pc_plus1;
                        fb_valid_d = 1'b0;
                    end
                end
                FETCH_S_DRAIN: begin
                    if (i_ready) begin
                        req_addr_d = pc_q;
                    end
                end
                default: ;
            endcase
        end

        if (ir_write) begin
            if (consume) begin
                ifid_inst_d     = fb_q;
                ifid_pc_plus1_d = pc_plus1;
                ifid_valid_d    = 1'b1;
            end else begin
                ifid_valid_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q            <= RESET_PC;
            req_addr_q      <= RESET_PC;
            fb_q            <= '0;
            fb_valid_q      <= 1'b0;
            ifid_inst_q     <= '0;
            ifid_pc_plus1_q <= '0;
            ifid_valid_q    <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            req_addr_q      <= req_addr_d;
            fb_q            <= fb_d;
            fb_valid_q      <= fb_valid_d;
            ifid_inst_q     <= ifid_inst_d;
            ifid_pc_plus1_q <= ifid_pc_plus1_d;
            ifid_valid_q    <= ifid_valid_d;
        end
    end

    assign ifid_inst     = ifid_inst_q;
    assign ifid_pc_plus1 = ifid_pc_plus1_q;
    assign ifid_valid    = ifid_valid_q;

`ifdef FETCH_NUM_INST_EN
    logic [WORD_SIZE-1:0] num_inst_q, num_inst_d;

    always_comb begin
        num_inst_d = num_inst_q;
        if (incr_num_inst & ifid_valid_q & ir_write) begin
            num_inst_d = num_inst_q + WORD_SIZE'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_inst_q <= '0;
        end else begin
            num_inst_q <= num_inst_d;
        end
    end

    assign num_inst = num_inst_q;
`else
    logic unused_incr_num_inst;
    assign unused_incr_num_inst = incr_num_inst;
    assign num_inst             = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected imem addresses and IF/ID contents are queued by the stimulus, popped by a monitor.
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        pc_write;
    logic        ir_write;
    logic        flush;
    logic [15:0] flush_target;
    logic        incr_num_inst;
    logic        i_read_req;
    logic [15:0] i_address;
    logic [15:0] i_data;
    logic        i_ready;
    logic [15:0] ifid_inst;
    logic [15:0] ifid_pc_plus1;
    logic        ifid_valid;
    logic [15:0] num_inst;

    int errors = 0;
    int checks = 0;

    logic [15:0] hs_exp[$];
    logic [15:0] ifid_exp[$];
    logic        prev_irw = 1'b0;
    logic [15:0] mon_e;

    fetch_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pc_write      (pc_write),
        .ir_write      (ir_write),
        .flush         (flush),
        .flush_target  (flush_target),
        .incr_num_inst (incr_num_inst),
        .i_read_req    (i_read_req),
        .i_address     (i_address),
        .i_data        (i_data),
        .i_ready       (i_ready),
        .ifid_inst     (ifid_inst),
        .ifid_pc_plus1 (ifid_pc_plus1),
        .ifid_valid    (ifid_valid),
        .num_inst      (num_inst)
    );

    // Memory image: each word is its address XOR a fixed pattern.
    assign i_data = i_address ^ 16'hC300;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic push_hs(input logic [15:0] a);
        hs_exp.push_back(a);
    endtask

    task automatic push_ifid(input logic [15:0] a);
        ifid_exp.push_back(a);
    endtask

    // Inputs change 2 time units after posedge, so at negedge they are what the next edge sees.
    always @(negedge clk) begin
        if (reset_n) begin
            if (prev_irw && ifid_valid) begin
                if (ifid_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ifid_extra: got unexpected inst %h pc+1 %h, expected none", ifid_inst, ifid_pc_plus1);
                end else begin
                    mon_e = ifid_exp.pop_front();
                    chk("ifid_inst", ifid_inst, mon_e ^ 16'hC300);
                    chk("ifid_pc_plus1", ifid_pc_plus1, mon_e + 16'd1);
                end
            end
            if (i_read_req && i_ready) begin
                if (hs_exp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL hs_extra: got unexpected read of %h, expected none", i_address);
                end else begin
                    mon_e = hs_exp.pop_front();
                    chk("i_address", i_address, mon_e);
                end
            end
`ifndef FETCH_NUM_INST_EN
            chk("num_inst_off", num_inst, 16'h0000);
`endif
        end
        prev_irw = reset_n && ir_write;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n       = 1'b0;
        pc_write      = 1'b1;
        ir_write      = 1'b1;
        flush         = 1'b0;
        flush_target  = 16'h0000;
        incr_num_inst = 1'b0;
        i_ready       = 1'b1;
        repeat (3) cyc();

        chk("rst_req", {15'd0, i_read_req}, 16'h0000);
        chk("rst_valid", {15'd0, ifid_valid}, 16'h0000);
        chk("rst_inst", ifid_inst, 16'h0000);
        chk("rst_pcp1", ifid_pc_plus1, 16'h0000);
        chk("rst_num", num_inst, 16'h0000);

        // Streaming with i_ready tied high.
        for (int a = 0; a < 5; a++) push_hs(16'(a));
        for (int a = 0; a < 4; a++) push_ifid(16'(a));
        reset_n = 1'b1;
        #1;
        chk("rel_req", {15'd0, i_read_req}, 16'h0001);
        chk("rel_addr", i_address, 16'h0000);
        repeat (8) cyc();

        // Stall: read of 4 completes, then S_HAVE holds for 3 cycles.
        pc_write = 1'b0;
        ir_write = 1'b0;
        repeat (3) begin
            cyc();
            chk("hold_req", {15'd0, i_read_req}, 16'h0000);
            chk("hold_valid", {15'd0, ifid_valid}, 16'h0001);
            chk("hold_pcp1", ifid_pc_plus1, 16'h0004);
            chk("hold_inst", ifid_inst, 16'h0003 ^ 16'hC300);
        end

        // Flush in S_HAVE: buffered word 4 is discarded.
        pc_write     = 1'b1;
        ir_write     = 1'b1;
        flush        = 1'b1;
        flush_target = 16'h0040;
        push_hs(16'h0040);
        push_ifid(16'h0040);
        cyc();
        flush = 1'b0;
        chk("flh_addr", i_address, 16'h0040);
        repeat (2) cyc();

        // Flush in S_REQ with memory stalled: old read drains, then target.
        i_ready      = 1'b0;
        flush        = 1'b1;
        flush_target = 16'h0080;
        push_hs(16'h0041);
        push_hs(16'h0080);
        push_ifid(16'h0080);
        cyc();
        flush = 1'b0;
        chk("drn_req", {15'd0, i_read_req}, 16'h0001);
        chk("drn_addr0", i_address, 16'h0041);
        cyc();
        chk("drn_addr1", i_address, 16'h0041);
        cyc();
        chk("drn_addr2", i_address, 16'h0041);
        i_ready = 1'b1;
        cyc();
        chk("drn_next", i_address, 16'h0080);
        repeat (2) cyc();

        // Flush coincident with i_ready: returning data loses to the target.
        flush        = 1'b1;
        flush_target = 16'h0090;
        push_hs(16'h0081);
        push_hs(16'h0090);
        push_ifid(16'h0090);
        cyc();
        flush = 1'b0;
        repeat (2) cyc();

        // PC wrap from FFFF to 0000.
        flush        = 1'b1;
        flush_target = 16'hFFFF;
        push_hs(16'h0091);
        push_hs(16'hFFFF);
        push_hs(16'h0000);
        push_ifid(16'hFFFF);
        push_ifid(16'h0000);
        cyc();
        flush = 1'b0;
        repeat (4) cyc();

        // Reset asserted mid-drain.
        i_ready      = 1'b0;
        flush        = 1'b1;
        flush_target = 16'h0200;
        cyc();
        flush = 1'b0;
        cyc();
        chk("mid_drain_addr", i_address, 16'h0001);
        reset_n = 1'b0;
        #1;
        chk("arst_req", {15'd0, i_read_req}, 16'h0000);
        chk("arst_valid", {15'd0, ifid_valid}, 16'h0000);
        chk("arst_inst", ifid_inst, 16'h0000);
        chk("arst_pcp1", ifid_pc_plus1, 16'h0000);
        chk("arst_num", num_inst, 16'h0000);
        cyc();
        i_ready = 1'b1;

        // Restart from RESET_PC and issue 5 instructions.
        for (int a = 0; a < 6; a++) push_hs(16'(a));
        for (int a = 0; a < 5; a++) push_ifid(16'(a));
        reset_n       = 1'b1;
        incr_num_inst = 1'b1;
        #1;
        chk("rst2_req", {15'd0, i_read_req}, 16'h0001);
        chk("rst2_addr", i_address, 16'h0000);
        repeat (11) cyc();
`ifdef FETCH_NUM_INST_EN
        chk("num_inst", num_inst, 16'd5);
`else
        chk("num_inst", num_inst, 16'd0);
`endif
        incr_num_inst = 1'b0;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        repeat (2) cyc();

        chk("hs_left", 16'(hs_exp.size()), 16'd0);
        chk("ifid_left", 16'(ifid_exp.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
